store_narrow_rmw: RTL
=====================

Name: store_narrow_rmw

Overview:
- Store-side counterpart of the load-path widening logic.
- Narrows a 32-bit register value to a byte, halfword or word store, aligned to its lane in a 32-bit word-addressed data memory that has no byte enables.
- Sub-word stores run as a read-modify-write over a req/ack memory handshake; word stores write directly.
- Sits between the datapath store port and data memory; raises an error for misaligned or illegal-size stores.

Parameters:
- ADDR_W, 32, byte-address width of st_addr and mem_addr.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request present.
- st_ready  output  1  block idle and able to accept a request.
- st_addr  input  ADDR_W  byte address of the store.
- st_data  input  32  register value; the low bits are used for sub-word stores.
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- st_done  output  1  one-cycle pulse when the store completes or is rejected.
- st_err  output  1  one-cycle pulse, coincident with st_done, when the store is rejected.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  ADDR_W  word-aligned address {st_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  output  32  merged write word.
- mem_rdata  input  32  read data; valid in a cycle where mem_req=1, mem_we=0 and mem_ack=1.
- mem_ack  input  1  memory completes the current access this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE.
  - st_ready=1 from the next cycle.
  - st_done=0, st_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal address, data and size registers cleared.
  - Reset mid-operation abandons the access; mem_req drops at that edge, with no write and no st_done.
- States: IDLE, RD, MERGE, WR, DONE.
- IDLE:
  - st_ready=1; a request is accepted on st_valid & st_ready.
  - On accept, st_addr, st_data and st_size are registered.
  - Illegal: size 11, or half with addr[0]=1, or word with addr[1:0]!=0. Next state DONE with error flag set; no memory access.
  - Word, aligned: next state WR, mem_wdata = st_data.
  - Byte or half, aligned: next state RD.
- RD:
  - mem_req=1, mem_we=0, mem_addr = aligned address.
  - On mem_ack, capture mem_rdata and go to MERGE; otherwise hold.
- MERGE (one cycle):
  - Little-endian lanes: byte k occupies bits [8k+7:8k].
  - Byte store: lane addr[1:0] replaced by st_data[7:0].
  - Half store: lanes addr[1]*2 and addr[1]*2+1 replaced by st_data[15:0].
  - Other lanes keep the read value; st_data upper bits are ignored.
  - Result registered to mem_wdata; next state WR.
- WR:
  - mem_req=1, mem_we=1.
  - mem_addr and mem_wdata stable until mem_ack; then DONE.
- DONE:
  - st_done=1 for exactly one cycle; st_err=1 only if the error flag is set.
  - Next state IDLE. st_ready=0 in every state except IDLE.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata do not change while mem_req=1 and mem_ack=0.
  - mem_ack is sampled only while mem_req=1; ack while mem_req=0 is ignored.
  - mem_req deasserts in the cycle after ack.
- Latency with zero-wait ack (cycle 0 = accept edge):
  - Word: WR in cycle 1, st_done in cycle 2.
  - Byte/half: RD in cycle 1, MERGE in cycle 2, WR in cycle 3, st_done in cycle 4.
  - Illegal: st_done + st_err in cycle 1.
  - Each wait cycle on mem_ack adds one cycle.
- st_valid while not ready is ignored; the requester holds it.
- No back-to-back accept in the DONE cycle; the next accept is earliest in the following IDLE cycle.
- Address wrap-around is not special-cased; the aligned address is used as is.

Test Plan:
- Memory[0x100]=0xAABBCCDD; byte store st_data=0x123456EF, addr=0x102 -> read of 0x100, write of 0xAAEFCCDD, st_done 4 cycles after accept, st_err=0.
- Same memory; half store st_data=0xFFFFBEEF, addr=0x102 -> write 0xBEEFCCDD. Same data with addr=0x100 -> write 0xAABBBEEF.
- Word store 0xDEADBEEF, addr=0x104 -> no read cycle; single write of 0xDEADBEEF to 0x104; st_done 2 cycles after accept.
- Half store at addr=0x101, then word store at addr=0x106, then size=11 -> each gives st_done+st_err one cycle after accept; mem_req never asserted.
- Byte store with mem_ack delayed 3 cycles on both read and write -> mem_req/mem_we/mem_addr/mem_wdata stable throughout each wait; st_done 10 cycles after accept; st_valid asserted during busy is not accepted.
- rst pulsed while in RD with mem_req=1 -> mem_req=0 the next cycle, no write issued, no st_done, st_ready=1 afterwards; a following byte store completes normally.

Source files
------------

// File: rtl/store_narrow_rmw.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow_rmw
// Purpose  : Narrows byte/half/word stores onto a byte-enable-less word memory,
//            using read-modify-write for sub-word stores.
// Revision : 1.0
// ============================================================================

module store_narrow_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [15:0]       data_q,  data_d;
  logic [1:0]        size_q,  size_d;
  logic              err_q,   err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic              illegal;
  logic [31:0]       merged;

  assign accept = st_valid & (state_q == S_IDLE);

  always_comb begin
    illegal = 1'b0;
    case (st_size)
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = st_addr[0];
      SZ_WORD: illegal = (st_addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Only the addressed lane(s) take store data; every other lane keeps the read value.
  always_comb begin
    merged = rdata_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = data_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: merged = rdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = st_addr;
          data_d = st_data[15:0];
          size_d = st_size;
          err_d  = illegal;
          if (illegal) begin
            state_d = S_DONE;
          end else if (st_size == SZ_WORD) begin
            wdata_d = st_data;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = S_MERGE;
        end
      end
      S_MERGE: begin
        wdata_d = merged;
        state_d = S_WR;
      end
      S_WR: begin
        if (mem_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs decode straight from registered state, so they cannot move during an ack wait.
  assign st_ready  = (state_q == S_IDLE);
  assign st_done   = (state_q == S_DONE);
  assign st_err    = (state_q == S_DONE) & err_q;
  assign mem_req   = (state_q == S_RD) | (state_q == S_WR);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

`default_nettype wire
